// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous single-port ROM.
// One read is issued per cycle, and its data returns to the issuing port one cycle later.
module rom_port_arbiter #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic [ADDR_BITS-1:0]  addr_a,
    output logic                  grant_a,
    output logic                  valid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic [ADDR_BITS-1:0]  addr_b,
    output logic                  grant_b,
    output logic                  valid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    input  logic                  lock_a,
    output logic                  rom_en,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    // state  | meaning
    // IDLE   | no read in flight; rom_data is not owed to anyone
    // RESP_A | read issued last cycle for port A; rom_data belongs to A
    // RESP_B | read issued last cycle for port B; rom_data belongs to B
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_A = 2'd1,
        RESP_B = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_b;
    logic                  last_b_next;
    logic [DATA_WIDTH-1:0] hold_a;
    logic [DATA_WIDTH-1:0] hold_b;

    // Grant selection; on contention the port that did not win last time goes first.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (req_a && req_b) begin
                if (lock_a || last_b) grant_a = 1'b1;
                else                  grant_b = 1'b1;
            end else if (req_a) begin
                grant_a = 1'b1;
            end else if (req_b && !lock_a) begin
                grant_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            last_b <= 1'b1;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            state  <= state_next;
            last_b <= last_b_next;
            if (valid_a) hold_a <= rom_data;
            if (valid_b) hold_b <= rom_data;
        end
    end

    always_comb begin
        state_next  = IDLE;
        last_b_next = last_b;
        if (grant_a) begin
            state_next  = RESP_A;
            last_b_next = 1'b0;
        end else if (grant_b) begin
            state_next  = RESP_B;
            last_b_next = 1'b1;
        end
    end

    // Reset squashes a response that was already in flight.
    always_comb begin
        valid_a  = (state == RESP_A) && !reset;
        valid_b  = (state == RESP_B) && !reset;
        rdata_a  = valid_a ? rom_data : hold_a;
        rdata_b  = valid_b ? rom_data : hold_b;
        rom_en   = grant_a | grant_b;
        rom_addr = grant_b ? addr_b : addr_a;
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: a behavioural ROM and arbitration model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, lock_a;
    logic [9:0]  addr_a, addr_b;
    logic        grant_a, grant_b, valid_a, valid_b, rom_en;
    logic [15:0] rdata_a, rdata_b;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_BITS(10), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .addr_a(addr_a), .grant_a(grant_a), .valid_a(valid_a), .rdata_a(rdata_a),
        .req_b(req_b), .addr_b(addr_b), .grant_b(grant_b), .valid_b(valid_b), .rdata_b(rdata_b),
        .lock_a(lock_a), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    // ROM contents: word = 0xA000 + address.
    function automatic logic [15:0] rom_word(input logic [9:0] a);
        return {6'h28, a};
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: winner history, the one read in flight, and the last word each port received.
    int          m_last = 2;
    bit          m_pend = 1'b0;
    int          m_pport = 0;
    logic [9:0]  m_paddr = '0;
    logic [15:0] m_hold [2] = '{16'h0, 16'h0};
    int          g;
    bit          ev_a, ev_b;

    always @(negedge clk) begin
        if (model_on) begin
            g = 0;
            if (!reset) begin
                if (req_a && req_b) g = lock_a ? 1 : ((m_last == 2) ? 1 : 2);
                else if (req_a) g = 1;
                else if (req_b && !lock_a) g = 2;
            end
            chk("m_grant_a", grant_a, g == 1);
            chk("m_grant_b", grant_b, g == 2);
            chk("m_rom_en", rom_en, g != 0);
            if (g != 0) chk("m_rom_addr", rom_addr, (g == 1) ? addr_a : addr_b);
            ev_a = !reset && m_pend && (m_pport == 1);
            ev_b = !reset && m_pend && (m_pport == 2);
            chk("m_valid_a", valid_a, ev_a);
            chk("m_valid_b", valid_b, ev_b);
            chk("m_rdata_a", rdata_a, ev_a ? rom_word(m_paddr) : m_hold[0]);
            chk("m_rdata_b", rdata_b, ev_b ? rom_word(m_paddr) : m_hold[1]);
            if (reset) begin
                m_last = 2;
                m_pend = 1'b0;
                m_hold[0] = 16'h0;
                m_hold[1] = 16'h0;
            end else begin
                if (ev_a) m_hold[0] = rom_word(m_paddr);
                if (ev_b) m_hold[1] = rom_word(m_paddr);
                m_pend  = (g != 0);
                m_pport = g;
                m_paddr = (g == 2) ? addr_b : addr_a;
                if (g != 0) m_last = g;
            end
        end
    end

    task automatic step(input logic ra, input logic [9:0] aa, input logic rb,
                        input logic [9:0] ab, input logic lk, input logic rst);
        @(posedge clk);
        #1;
        req_a = ra; addr_a = aa; req_b = rb; addr_b = ab; lock_a = lk; reset = rst;
        @(negedge clk);
    endtask

    logic [9:0]  t5_addr [3] = '{10'h3FE, 10'h3FF, 10'h000};
    logic [15:0] t5_word [3] = '{16'hA3FE, 16'hA3FF, 16'hA000};

    initial begin
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; lock_a = 1'b0; addr_a = '0; addr_b = '0;
        @(posedge clk);
        #1;
        model_on = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        chk("reset_grant_a", grant_a, 0);
        chk("reset_rom_en", rom_en, 0);
        chk("reset_valid_b", valid_b, 0);

        // single port A read
        step(1, 10'h000, 0, 0, 0, 0);
        chk("t1_grant_a", grant_a, 1);
        chk("t1_rom_addr", rom_addr, 10'h000);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_valid_a", valid_a, 1);
        chk("t1_rdata_a", rdata_a, 16'hA000);
        chk("t1_rdata_b", rdata_b, 16'h0000);

        // continuous contention alternates A,B
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 10'h010, 1, 10'h200, 0, 0);
            chk("t2_grant_a", grant_a, (i % 2) == 0);
            if (i > 0) chk("t2_valid_a", valid_a, ((i - 1) % 2) == 0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("t2_last_valid_b", valid_b, 1);
        chk("t2_last_rdata_b", rdata_b, 16'hA200);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_hold_valid_a", valid_a, 0);
        chk("t2_hold_rdata_a", rdata_a, 16'hA010);

        // lock_a for three cycles
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 10'h010, 1, 10'h200, (i < 3), 0);
            chk("t3_grant_a", grant_a, (i < 3) || (i == 4));
            chk("t3_valid_b", valid_b, i == 4);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("t3_tail_valid_b", valid_b, 1);

        // reset right after a grant discards the read
        step(1, 10'h055, 0, 0, 0, 0);
        chk("t4_grant_a", grant_a, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t4_valid_a_rst", valid_a, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_valid_a_post", valid_a, 0);
        chk("t4_rdata_a_post", rdata_a, 16'h0000);
        step(1, 10'h055, 1, 10'h100, 0, 0);
        chk("t4_contend_a", grant_a, 1);
        chk("t4_contend_b", grant_b, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_rdata_a", rdata_a, 16'hA055);

        // lock_a blocks a lone B, then B streams with wrap
        step(0, 0, 1, 10'h3FE, 1, 0);
        chk("t5_locked_grant_b", grant_b, 0);
        chk("t5_locked_rom_en", rom_en, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(0, 0, 1, t5_addr[i], 0, 0);
            else       step(0, 0, 0, 0, 0, 0);
            chk("t5_grant_b", grant_b, i < 3);
            if (i > 0) begin
                chk("t5_valid_b", valid_b, 1);
                chk("t5_rdata_b", rdata_b, t5_word[i-1]);
            end
        end

        // idle bus with random addresses
        for (int i = 0; i < 8; i++) begin
            step(0, 10'($urandom), 0, 10'($urandom), 0, 0);
            chk("t6_rom_en", rom_en, 0);
            chk("t6_valid", {valid_a, valid_b}, 2'b00);
        end
        chk("t6_hold_a", rdata_a, 16'hA055);
        chk("t6_hold_b", rdata_b, 16'hA000);

        @(posedge clk);
        #1;
        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
